// File: rtl/td4_sequencer.sv
// td4_sequencer: two-state fetch/execute controller for the TD4 4-bit CPU
module td4_sequencer #(
    parameter int bitWidth = 4
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                en,
    input  logic [7:0]          insn,
    input  logic                c_in,
    output logic [bitWidth-1:0] addr,
    output logic [2:0]          load_n,
    output logic [1:0]          sel,
    output logic [bitWidth-1:0] im,
    output logic                carry,
    output logic                exec
);
    typedef enum logic {FETCH, EXEC} state_t;
    state_t              state;
    logic [7:0]          ir;
    logic [bitWidth-1:0] pc;
    logic [3:0]          op;
    logic                jump;
    assign op   = ir[7:4];
    assign im   = bitWidth'(ir[3:0]);
    assign addr = pc;
    assign exec = state == EXEC;
    assign jump = op == 4'hf || (op == 4'he && !carry);
    // decode selector and load strobes purely from the latched instruction and state
    always_comb begin
        sel    = !op[3] ? op[1:0] : op == 4'h9 ? 2'b01 : 2'b11;
        load_n = !exec ? 3'b111 :
                 !op[3] ? (op[2] ? 3'b101 : 3'b110) :
                 (op == 4'h9 || op == 4'hb) ? 3'b011 : 3'b111;
    end
    // fetch latches the instruction; exec advances pc and captures carry
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= FETCH;
            ir    <= 8'h00;
            pc    <= '0;
            carry <= 1'b0;
        end else if (state == FETCH) begin
            if (en) begin
                ir    <= insn;
                state <= EXEC;
            end
        end else begin
            state <= FETCH;
            carry <= c_in;
            pc    <= jump ? im : pc + 1'b1;
        end
    end
endmodule

// File: tb/tb_td4_sequencer.sv
// tb_td4_sequencer: directed scoreboard bench for the fetch/execute sequencer
module tb_td4_sequencer;
    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       en = 1'b0;
    logic [7:0] insn = 8'h00;
    logic       c_in = 1'b0;
    logic [3:0] addr, im;
    logic [2:0] load_n;
    logic [1:0] sel;
    logic       carry, exec;

    td4_sequencer #(.bitWidth(4)) dut (
        .clk(clk), .clr(clr), .en(en), .insn(insn), .c_in(c_in),
        .addr(addr), .load_n(load_n), .sel(sel), .im(im),
        .carry(carry), .exec(exec)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [14:0] val;
    } exp_t;
    exp_t q[$];
    int checks = 0;
    int errors = 0;
    logic [3:0] m_pc = 4'd0;
    logic       m_carry = 1'b0;
    logic [7:0] m_ir = 8'h00;

    function automatic logic [14:0] pack(input logic x, input logic [2:0] ln, input logic [1:0] s,
                                         input logic [3:0] i, input logic [3:0] a, input logic c);
        return {x, ln, s, i, a, c};
    endfunction

    // expected {load_n while executing, sel} straight from the opcode table
    function automatic logic [4:0] table_of(input logic [3:0] op);
        case (op)
            4'h0: return {3'b110, 2'b00};
            4'h1: return {3'b110, 2'b01};
            4'h2: return {3'b110, 2'b10};
            4'h3: return {3'b110, 2'b11};
            4'h4: return {3'b101, 2'b00};
            4'h5: return {3'b101, 2'b01};
            4'h6: return {3'b101, 2'b10};
            4'h7: return {3'b101, 2'b11};
            4'h9: return {3'b011, 2'b01};
            4'hb: return {3'b011, 2'b11};
            default: return {3'b111, 2'b11};
        endcase
    endfunction

    task automatic push(input string tag, input logic [14:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        logic [14:0] obs;
        obs = pack(exec, load_n, sel, im, addr, carry);
        if (q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty: got %h expected an entry", obs);
        end else begin
            e = q.pop_front();
            checks++;
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: got %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    // run one instruction from a negedge; optionally drop en during exec
    task automatic do_insn(input string tag, input logic [7:0] ins, input logic cin, input logic drop);
        logic [4:0] t;
        logic [3:0] nxt;
        t = table_of(ins[7:4]);
        en = 1'b1;
        insn = ins;
        m_ir = ins;
        @(posedge clk);
        @(negedge clk);
        if (drop) en = 1'b0;
        c_in = cin;
        insn = ~ins;
        push({tag, "_exec"}, pack(1'b1, t[4:2], t[1:0], ins[3:0], m_pc, m_carry));
        pop_check();
        nxt = (ins[7:4] == 4'hf || (ins[7:4] == 4'he && !m_carry)) ? ins[3:0] : m_pc + 4'd1;
        m_pc = nxt;
        m_carry = cin;
        @(negedge clk);
        push({tag, "_fetch"}, pack(1'b0, 3'b111, t[1:0], ins[3:0], m_pc, m_carry));
        pop_check();
    endtask

    initial begin
        logic [4:0] t;
        #3;
        push("reset", pack(1'b0, 3'b111, 2'b00, 4'h0, 4'h0, 1'b0));
        pop_check();
        clr = 1'b1;
        @(negedge clk);
        do_insn("mov_a_im", 8'h35, 1'b1, 1'b0);
        do_insn("out_b", 8'h90, 1'b0, 1'b0);
        do_insn("nop_a0", 8'ha0, 1'b1, 1'b0);
        do_insn("jnc_not_taken", 8'he7, 1'b0, 1'b0);
        do_insn("jnc_taken", 8'he7, 1'b0, 1'b0);
        do_insn("add_b_im", 8'h5c, 1'b1, 1'b0);
        do_insn("jmp_15", 8'hff, 1'b1, 1'b0);
        do_insn("wrap", 8'h00, 1'b0, 1'b0);
        do_insn("jmp_3", 8'hf3, 1'b1, 1'b0);
        do_insn("mov_b_a", 8'h46, 1'b0, 1'b0);
        do_insn("out_im", 8'hb9, 1'b1, 1'b0);
        do_insn("nop_c0", 8'hc4, 1'b0, 1'b0);
        do_insn("in_b", 8'h62, 1'b1, 1'b0);
        en = 1'b0;
        t = table_of(m_ir[7:4]);
        for (int i = 0; i < 5; i++) begin
            insn = 8'($urandom);
            c_in = ~m_carry;
            @(negedge clk);
            push("idle", pack(1'b0, 3'b111, t[1:0], m_ir[3:0], m_pc, m_carry));
            pop_check();
        end
        do_insn("en_drop", 8'h12, 1'b1, 1'b1);
        en = 1'b1;
        insn = 8'h45;
        m_ir = 8'h45;
        @(posedge clk);
        @(negedge clk);
        c_in = 1'b0;
        push("mid_exec", pack(1'b1, 3'b101, 2'b00, 4'h5, m_pc, 1'b1));
        pop_check();
        #2 clr = 1'b0;
        #1;
        push("async_clr", pack(1'b0, 3'b111, 2'b00, 4'h0, 4'h0, 1'b0));
        pop_check();
        en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        push("held_clr", pack(1'b0, 3'b111, 2'b00, 4'h0, 4'h0, 1'b0));
        pop_check();
        clr = 1'b1;
        m_pc = 4'd0;
        m_carry = 1'b0;
        do_insn("after_clr", 8'h2a, 1'b1, 1'b0);
        if (q.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_leftover: got %0d entries expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/td4_sequencer.md
TD4_SEQUENCER -- requirements
Module: td4_sequencer

Interface
REQ-001 The parameter list SHALL be: bitWidth, 4, width of PC, IM field and ADDR.
REQ-002 Ports SHALL be one per line as below; one clock; reset is asynchronous and active-low.
REQ-003 CLK  input  1  system clock; all state changes on the rising edge.
REQ-004 CLR  input  1  asynchronous active-low reset.
REQ-005 EN  input  1  run enable, active-high; sampled only in FETCH.
REQ-006 INSN  input  8  instruction byte from ROM at ADDR: [7:4] opcode, [3:0] IM.
REQ-007 C_IN  input  1  ALU carry-out for the current EXEC cycle.
REQ-008 ADDR  output  bitWidth  program counter value, drives ROM address.
REQ-009 LOAD_N  output  3  active-low CS strobes to the registers: [0] A, [1] B, [2] OUT.
REQ-010 SEL  output  2  data selector: 00 A, 01 B, 10 IN port, 11 zero.
REQ-011 IM  output  bitWidth  immediate field of the latched instruction.
REQ-012 CARRY  output  1  carry flag.
REQ-013 EXEC  output  1  high during the EXEC state.

Function
REQ-014 The block SHALL be a two-state FSM: FETCH and EXEC.
REQ-015 FETCH with EN=1: latch INSN into IR, then go to EXEC; with EN=0: stay in FETCH and hold IR, PC and CARRY.
REQ-016 EXEC SHALL last exactly one cycle and then return to FETCH unconditionally, regardless of EN; each instruction takes 2 cycles.
REQ-017 LOAD_N, SEL and IM SHALL be decoded only from IR and state, with no combinational path from INSN, C_IN or EN.
REQ-018 LOAD_N SHALL be 3'b111 in FETCH.
REQ-019 In EXEC, at most one LOAD_N bit SHALL be low, so the target register captures on the edge that ends EXEC.
REQ-020 Decode table (opcode: SEL, target):
- 0000 ADD A,Im: 00, A
- 0001 MOV A,B: 01, A
- 0010 IN A: 10, A
- 0011 MOV A,Im: 11, A
- 0100 MOV B,A: 00, B
- 0101 ADD B,Im: 01, B
- 0110 IN B: 10, B
- 0111 MOV B,Im: 11, B
- 1001 OUT B: 01, OUT
- 1011 OUT Im: 11, OUT
- 1110 JNC Im: 11, none
- 1111 JMP Im: 11, none
REQ-021 Opcodes 1000, 1010, 1100 and 1101 SHALL be NOPs: LOAD_N=111, SEL=11, PC increments, CARRY still updates.
REQ-022 On the edge ending EXEC, PC SHALL become IM for JMP, or for JNC with CARRY=0; otherwise PC+1 modulo 2^bitWidth (so 15 wraps to 0).
REQ-023 JNC SHALL test the CARRY value registered before its own EXEC, not C_IN.
REQ-024 On the edge ending EXEC, CARRY SHALL load C_IN for every opcode, including jumps and NOPs.
REQ-025 PC, CARRY and IR SHALL NOT change on the edge ending FETCH, except the IR latch.
REQ-026 IM SHALL equal IR[3:0] in both states.
REQ-027 EXEC output SHALL be high exactly when the state is EXEC.

Reset
REQ-028 CLR low SHALL immediately, without waiting for a clock, force:
- state FETCH, PC=0, IR=8'h00, CARRY=0
- LOAD_N=111, SEL=00, IM=0, EXEC=0
REQ-029 CLR asserted during EXEC SHALL negate LOAD_N at once, so no register load and no PC or CARRY update occur.
REQ-030 After CLR rises, the first rising edge with EN=1 SHALL fetch from ADDR 0.

Verification
REQ-031 Reset then EN=1, INSN=8'h35 (MOV A,5) -> in EXEC: LOAD_N=110, SEL=11, IM=5; after EXEC: ADDR=1, CARRY=C_IN.
REQ-032 INSN=8'h90 (OUT B) -> in EXEC: LOAD_N=011, SEL=01; INSN=8'hA0 (undefined) -> LOAD_N=111, ADDR increments.
REQ-033 Preceding EXEC with C_IN=1, then 8'hE7 (JNC 7) -> not taken, ADDR=PC+1; with prior C_IN=0 -> ADDR=7.
REQ-034 PC=15, INSN=8'h00 -> ADDR=0 after EXEC; INSN=8'hF3 at any PC -> ADDR=3.
REQ-035 EN=0 in FETCH for 5 cycles -> ADDR, CARRY and LOAD_N unchanged; EN dropped during EXEC -> instruction still completes.
REQ-036 CLR pulsed low mid-EXEC of 8'h45 -> LOAD_N=111 immediately, ADDR=0, CARRY=0, no B load observed.
